fix_seq_checker: RTL and testbench

Receive-side counterpart of the outbound FIX sequence numbering. It taps the inbound AXI4-Stream after the RX queues and locates the FIX MsgSeqNum field (SOH "34=" digits SOH) in each packet, then converts it to 6-digit packed BCD. It compares that value against the expected inbound sequence number and pushes one {status, number} result per packet into a small fall-through FIFO for the session process. The tap is passive: it has no tready and never stalls the datapath.

---
 rtl/fix_pkg.sv | 39 +++
 rtl/fallthrough_small_fifo.sv | 54 +++++
 rtl/fix_seq_checker.sv | 151 +++++++++++++++
 tb/tb_fix_seq_checker.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fix_pkg.sv
// Shared FIX constants, result status encoding and the 6-digit packed-BCD increment
// used by both the TX sequence generator and the RX sequence checker.
package fix_pkg;

  localparam logic [7:0]  FIX_SOH       = 8'h01;
  localparam logic [7:0]  FIX_TAG_3     = 8'h33;  // '3'
  localparam logic [7:0]  FIX_TAG_4     = 8'h34;  // '4'
  localparam logic [7:0]  FIX_TAG_EQ    = 8'h3D;  // '='
  localparam logic [7:0]  FIX_ASCII_0   = 8'h30;
  localparam logic [7:0]  FIX_ASCII_9   = 8'h39;
  localparam logic [23:0] FIX_SEQ_RESET = 24'h000001;

  typedef enum logic [1:0] {
    IN_ORDER = 2'd0,
    GAP      = 2'd1,
    LOW      = 2'd2,
    NOTAG    = 2'd3
  } seq_status_e;

  // Ripple-carry decimal increment; 999999 wraps to 000000.
  function automatic logic [23:0] bcd_inc6(input logic [23:0] v);
    logic [23:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO: the head entry is visible on o_dout whenever
// o_empty is low. Writes while full and reads while empty are ignored.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 26,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_wr_en,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;

  logic [WIDTH-1:0]        r_mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] r_wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] r_rd_ptr;
  logic [MAX_DEPTH_BITS:0]   r_count;
  logic                      w_wr;
  logic                      w_rd;

  assign o_full  = (r_count == (MAX_DEPTH_BITS+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_wr    = i_wr_en && !o_full;
  assign w_rd    = i_rd_en && !o_empty;
  assign o_dout  = r_mem[r_rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; an entry is only observed after being written.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/fix_seq_checker.sv
// Passive tap on the inbound stream: finds MsgSeqNum (SOH "34=" digits SOH) in frame
// bytes 32..95, converts it to packed BCD, classifies it and queues one result per packet.
module fix_seq_checker
  import fix_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int FIFO_DEPTH_BITS      = 2
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  tkeep,
  input  logic                              tvalid,
  input  logic                              tlast,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   tuser,
  input  logic                              set_expected,
  input  logic [23:0]                       set_expected_num,
  output logic                              seq_chk_vld,
  output logic [23:0]                       seq_chk_num,
  output logic [1:0]                        seq_chk_status,
  input  logic                              rd_seq_chk,
  output logic                              seq_chk_drop,
  output logic [23:0]                       expected_num
);

  localparam logic [31:0] TAG_WORD = {FIX_TAG_EQ, FIX_TAG_4, FIX_TAG_3, FIX_SOH};

  logic [1:0]   r_beat;
  logic [511:0] r_window;
  logic         r_win_vld, r_s2_vld, r_s3_vld;
  logic         r_found, r_ok;
  logic [55:0]  r_cand;
  logic [23:0]  r_bcd, r_expected;
  logic         r_drop;

  logic         w_trigger, w_found, w_ok, w_digits_ok;
  logic [5:0]   w_idx;
  logic [567:0] w_ext;
  logic [55:0]  w_cand;
  logic [2:0]   w_pos;
  logic [23:0]  w_bcd, w_num;
  seq_status_e  w_status;
  logic [25:0]  w_dout;
  logic         w_full, w_empty;
  logic         w_unused;

  assign w_unused  = ^{tkeep, tuser};
  assign w_trigger = tvalid && ((r_beat == 2'd2) || (tlast && (r_beat < 2'd2)));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_beat     <= '0;
      r_win_vld  <= 1'b0;
      r_s2_vld   <= 1'b0;
      r_s3_vld   <= 1'b0;
      r_expected <= FIX_SEQ_RESET;
      r_drop     <= 1'b0;
    end else begin
      if (tvalid) begin
        if (tlast)                 r_beat <= '0;
        else if (r_beat != 2'd3)   r_beat <= r_beat + 2'd1;
      end
      r_win_vld <= w_trigger;
      r_s2_vld  <= r_win_vld;
      r_s3_vld  <= r_s2_vld;
      r_drop    <= r_s3_vld && w_full;
      if (set_expected)
        r_expected <= set_expected_num;
      else if (r_s3_vld && (w_status == IN_ORDER))
        r_expected <= bcd_inc6(r_expected);
    end
  end

  // Window and pipeline data are qualified by the valids above.
  always_ff @(posedge clk) begin
    if (tvalid) begin
      case (r_beat)
        2'd0:    r_window          <= '0;
        2'd1:    r_window[255:0]   <= tdata;
        2'd2:    r_window[511:256] <= tdata;
        default: ;
      endcase
    end
    r_found <= w_found;
    r_cand  <= w_cand;
    r_ok    <= w_ok;
    r_bcd   <= w_bcd;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 60; i >= 0; i--) begin
      if (r_window[8*i +: 32] == TAG_WORD) begin
        w_found = 1'b1;
        w_idx   = 6'(i);
      end
    end
  end

  // Bytes past the window read as zero, so an unterminated field fails the SOH test.
  assign w_ext  = {56'd0, r_window};
  assign w_cand = w_ext[8*w_idx + 32 +: 56];

  always_comb begin
    w_pos       = 3'd7;
    w_digits_ok = 1'b1;
    w_bcd       = '0;
    for (int k = 6; k >= 0; k--)
      if (r_cand[8*k +: 8] == FIX_SOH) w_pos = 3'(k);
    for (int k = 0; k < 6; k++)
      if ((k < int'(w_pos)) &&
          ((r_cand[8*k +: 8] < FIX_ASCII_0) || (r_cand[8*k +: 8] > FIX_ASCII_9)))
        w_digits_ok = 1'b0;
    for (int p = 0; p < 6; p++)
      if ((p < int'(w_pos)) && (w_pos != 3'd7))
        w_bcd[4*p +: 4] = 4'(r_cand[8*(int'(w_pos)-1-p) +: 8] - FIX_ASCII_0);
    w_ok = r_found && (w_pos >= 3'd1) && (w_pos <= 3'd6) && w_digits_ok;
  end

  always_comb begin
    w_num = r_ok ? r_bcd : '0;
    if (!r_ok)                   w_status = NOTAG;
    else if (r_bcd == r_expected) w_status = IN_ORDER;
    else if (r_bcd > r_expected)  w_status = GAP;
    else                          w_status = LOW;
  end

  fallthrough_small_fifo #(
    .WIDTH          (26),
    .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_result_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_din   ({w_status, w_num}),
    .i_wr_en (r_s3_vld),
    .i_rd_en (rd_seq_chk),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign seq_chk_vld    = !w_empty;
  assign seq_chk_status = seq_chk_vld ? w_dout[25:24] : 2'd0;
  assign seq_chk_num    = seq_chk_vld ? w_dout[23:0]  : 24'd0;
  assign seq_chk_drop   = r_drop;
  assign expected_num   = r_expected;

endmodule

// File: tb/tb_fix_seq_checker.sv
// Directed bench for fix_seq_checker: expected results are queued as packets are sent
// and compared against the FIFO head as results are read out.
module tb_fix_seq_checker;

  logic         clk = 1'b0;
  logic         resetn;
  logic [255:0] tdata;
  logic [31:0]  tkeep;
  logic         tvalid, tlast;
  logic [127:0] tuser;
  logic         set_expected;
  logic [23:0]  set_expected_num;
  logic         seq_chk_vld;
  logic [23:0]  seq_chk_num;
  logic [1:0]   seq_chk_status;
  logic         rd_seq_chk;
  logic         seq_chk_drop;
  logic [23:0]  expected_num;

  logic [7:0]   frame [96];
  logic [25:0]  sb_q [$];
  int           n_pass  = 0;
  int           n_total = 0;
  int           drop_cnt = 0;

  always #5 clk = ~clk;

  fix_seq_checker #(
    .C_S_AXIS_DATA_WIDTH  (256),
    .C_S_AXIS_TUSER_WIDTH (128),
    .FIFO_DEPTH_BITS      (2)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .tdata            (tdata),
    .tkeep            (tkeep),
    .tvalid           (tvalid),
    .tlast            (tlast),
    .tuser            (tuser),
    .set_expected     (set_expected),
    .set_expected_num (set_expected_num),
    .seq_chk_vld      (seq_chk_vld),
    .seq_chk_num      (seq_chk_num),
    .seq_chk_status   (seq_chk_status),
    .rd_seq_chk       (rd_seq_chk),
    .seq_chk_drop     (seq_chk_drop),
    .expected_num     (expected_num)
  );

  always @(negedge clk) if (resetn && seq_chk_drop) drop_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 96; i++) frame[i] = 8'h00;
  endtask

  // Places SOH "34=" <digs> [SOH] starting at window byte w (frame byte 32+w).
  task automatic put_field(input int w, input string digs, input bit term);
    frame[32+w] = 8'h01;
    frame[33+w] = 8'h33;
    frame[34+w] = 8'h34;
    frame[35+w] = 8'h3D;
    for (int k = 0; k < digs.len(); k++) frame[36+w+k] = digs[k];
    if (term) frame[36+w+digs.len()] = 8'h01;
  endtask

  task automatic send_pkt(input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      @(negedge clk);
      for (int k = 0; k < 32; k++) tdata[8*k +: 8] = frame[32*b + k];
      tvalid = 1'b1;
      tlast  = (b == nbeats - 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      tvalid = 1'b0;
      tlast  = 1'b0;
    end
  endtask

  task automatic expect_res(input logic [1:0] st, input logic [23:0] num);
    sb_q.push_back({st, num});
  endtask

  task automatic set_exp(input logic [23:0] v);
    @(negedge clk);
    set_expected     = 1'b1;
    set_expected_num = v;
    @(negedge clk);
    set_expected     = 1'b0;
  endtask

  task automatic drain_one(input string tag);
    int          w;
    logic [25:0] exp;
    w   = 0;
    exp = '0;
    while (!seq_chk_vld && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_vld"}, 32'(seq_chk_vld), 32'd1);
    if (sb_q.size() > 0) exp = sb_q.pop_front();
    if (seq_chk_vld) begin
      check(tag, 32'({seq_chk_status, seq_chk_num}), 32'(exp));
      rd_seq_chk = 1'b1;
      @(negedge clk);
      rd_seq_chk = 1'b0;
    end
  endtask

  initial begin
    int drop0;
    resetn = 1'b0;
    tdata = '0; tkeep = '1; tvalid = 1'b0; tlast = 1'b0; tuser = '0;
    set_expected = 1'b0; set_expected_num = '0; rd_seq_chk = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_vld",    32'(seq_chk_vld),    32'd0);
    check("rst_num",    32'(seq_chk_num),    32'd0);
    check("rst_status", 32'(seq_chk_status), 32'd0);
    check("rst_drop",   32'(seq_chk_drop),   32'd0);
    check("rst_expect", 32'(expected_num),   32'h000001);
    resetn = 1'b1;

    // In order, with exact 4-cycle latency from the trigger beat.
    clear_frame(); put_field(10, "1", 1'b1);
    expect_res(2'd0, 24'h000001);
    send_pkt(3);
    idle(1);
    repeat (2) @(negedge clk);
    check("lat_t3_vld", 32'(seq_chk_vld), 32'd0);
    @(negedge clk);
    check("lat_t4_vld", 32'(seq_chk_vld), 32'd1);
    drain_one("in_order");
    check("inorder_expect", 32'(expected_num), 32'h000002);

    clear_frame(); put_field(10, "5", 1'b1);
    expect_res(2'd1, 24'h000005);
    send_pkt(3); idle(1);
    drain_one("gap");
    check("gap_expect", 32'(expected_num), 32'h000002);

    set_exp(24'h000010);
    check("set_expect", 32'(expected_num), 32'h000010);
    clear_frame(); put_field(10, "9", 1'b1);
    expect_res(2'd2, 24'h000009);
    send_pkt(3); idle(1);
    drain_one("low");
    check("low_expect", 32'(expected_num), 32'h000010);

    // Four malformed packets back to back: one NOTAG each.
    clear_frame(); put_field(10, "12a", 1'b1);     expect_res(2'd3, 24'h0); send_pkt(3);
    clear_frame(); put_field(10, "1234567", 1'b1); expect_res(2'd3, 24'h0); send_pkt(3);
    clear_frame();                                 expect_res(2'd3, 24'h0); send_pkt(2);
    clear_frame(); put_field(58, "12", 1'b0);      expect_res(2'd3, 24'h0); send_pkt(3);
    idle(1);
    drain_one("notag_alpha");
    drain_one("notag_7dig");
    drain_one("notag_2beat");
    drain_one("notag_nosoh");
    repeat (6) @(negedge clk);
    check("notag_no_extra", 32'(seq_chk_vld), 32'd0);
    check("notag_expect", 32'(expected_num), 32'h000010);

    // Tag straddling the beat-1/beat-2 boundary.
    clear_frame(); put_field(29, "10", 1'b1);
    expect_res(2'd0, 24'h000010);
    send_pkt(3); idle(1);
    drain_one("straddle");
    check("straddle_expect", 32'(expected_num), 32'h000011);

    set_exp(24'h999999);
    clear_frame(); put_field(0, "999999", 1'b1);
    expect_res(2'd0, 24'h999999);
    send_pkt(3); idle(1);
    drain_one("wrap");
    check("wrap_expect", 32'(expected_num), 32'h000000);

    // Load coincides with the IN_ORDER update at the end of T+3.
    clear_frame(); put_field(5, "0", 1'b1);
    expect_res(2'd0, 24'h000000);
    send_pkt(3);
    idle(1);
    @(negedge clk);
    @(negedge clk);
    set_expected = 1'b1; set_expected_num = 24'h000123;
    @(negedge clk);
    set_expected = 1'b0;
    check("set_wins_expect", 32'(expected_num), 32'h000123);
    drain_one("set_wins");

    @(negedge clk); rd_seq_chk = 1'b1;
    @(negedge clk); rd_seq_chk = 1'b0;
    check("rd_empty_vld", 32'(seq_chk_vld), 32'd0);

    // Five back-to-back packets into a depth-4 FIFO with no reads.
    set_exp(24'h000100);
    drop0 = drop_cnt;
    for (int k = 0; k < 5; k++) begin
      clear_frame(); put_field(10, $sformatf("%0d", 100 + k), 1'b1);
      if (k < 4) expect_res(2'd0, 24'h000100 + 24'(k));
      send_pkt(3);
    end
    idle(1);
    repeat (8) @(negedge clk);
    check("bp_drop_count", 32'(drop_cnt - drop0), 32'd1);
    check("bp_expect", 32'(expected_num), 32'h000105);
    for (int k = 0; k < 4; k++) drain_one($sformatf("bp_%0d", k));
    @(negedge clk);
    check("bp_empty", 32'(seq_chk_vld), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
